// File: rtl/bishift_pkg.sv
// Shared constants for the bishift_series_8 barrel shifter.
// WIDTH and SEL_W are tied together: SEL_W is log2(WIDTH).
package bishift_pkg;
    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/bishift_stage.sv
// One log-stage of the barrel shifter.
// When enabled, it shifts by AMT positions in the direction given by right and zero-fills.
module bishift_stage
    import bishift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             right,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        if (en) begin
            if (right == DIR_RIGHT) dout = din >> AMT;
            else                    dout = din << AMT;
        end
    end

endmodule

// File: rtl/bishift_series_8_reg.sv
// 8-bit bidirectional logical barrel shifter with a registered output.
// The three stages shift by 1, 2 and 4, and each stage is enabled by one bit of s_sel.
module bishift_series_8_reg
    import bishift_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic [SEL_W-1:0] s_sel,
    input  logic             right,
    output logic [WIDTH-1:0] out
);

    // chain[i] is the input to stage i, and chain[SEL_W] is the fully shifted value.
    logic [SEL_W:0][WIDTH-1:0] chain;

    assign chain[0] = data;

    for (genvar i = 0; i < SEL_W; i++) begin : g_stage
        bishift_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << i)
        ) u_stage (
            .din   (chain[i]),
            .en    (s_sel[i]),
            .right (right),
            .dout  (chain[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out <= '0;
        else        out <= chain[SEL_W];
    end

endmodule

// File: tb/tb_bishift_series_8_reg.sv
// Scoreboard bench for bishift_series_8_reg. The driver queues the expected results,
// and a monitor pops them and compares them one cycle later.
module tb_bishift_series_8_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic [2:0] s_sel;
    logic       right;
    logic [7:0] out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    bishift_series_8_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .s_sel (s_sel),
        .right (right),
        .out   (out)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic, truncated to 8 bits.
    function automatic logic [7:0] model(input int d, input int s, input bit r);
        int res;
        if (r) res = d / (2 ** s);
        else   res = (d * (2 ** s)) % 256;
        return res[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [7:0] d, input logic [2:0] s, input logic r);
        @(negedge clk);
        data  = d;
        s_sel = s;
        right = r;
        exp_q.push_back(model(int'(d), int'(s), r));
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && exp_q.size() > 0) check("scoreboard", out, exp_q.pop_front());
        end
    end

    initial begin : stim
        int wait_cycles;
        // Reset test: out is zero immediately and while reset is held.
        rst_n = 1'b0;
        data  = 8'hA5;
        s_sel = 3'd3;
        right = 1'b1;
        #1;
        check("reset_immediate", out, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h14);

        // Right shifts, left shifts, identity and extremes.
        for (int s = 1; s <= 4; s++) drive(8'b10100101, 3'(s), 1'b1);
        for (int s = 5; s <= 7; s++) drive(8'b10100101, 3'(s), 1'b0);
        drive(8'hA5, 3'd0, 1'b1);
        drive(8'hA5, 3'd0, 1'b0);
        drive(8'hFF, 3'd7, 1'b1);
        drive(8'hFF, 3'd7, 1'b0);

        // Toggle the direction back to back.
        for (int i = 0; i < 8; i++) drive(8'h81, 3'd1, 1'(i % 2 == 0));

        // Assert reset mid-stream: the pending result is discarded.
        drive(8'h3C, 3'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("midstream_reset", out, 8'h00);
        @(posedge clk);
        #1;
        check("midstream_reset_held", out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        data  = 8'h00;
        exp_q.push_back(model(0, int'(s_sel), right));

        // Exhaustive sweep.
        for (int d = 0; d < 256; d++)
            for (int s = 0; s < 8; s++)
                for (int r = 0; r < 2; r++)
                    drive(8'(d), 3'(s), 1'(r));

        // Random stimulus.
        for (int i = 0; i < 300; i++)
            drive(8'($urandom_range(255)), 3'($urandom_range(7)), 1'($urandom_range(1)));

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bishift_series_8_reg.md
# bishift_series_8_reg

Registered 8-bit bidirectional logical barrel shifter for the `bishift_series_8` block. It is built as a series of three log-stages that shift by 1, 2 and 4 positions, and each stage is enabled by one bit of the shift select. Direction is chosen by `right`, and vacated bit positions are always zero-filled. It sits in the datapath as a single-cycle shift unit with a registered output.

## Interface
- `WIDTH`, 8: data width. Fixed at 8 for this block. Stage count is log2(WIDTH) = 3.
- `clk` input 1: sole clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `data` input 8: operand to shift.
- `s_sel` input 3: shift amount, 0–7.
- `right` input 1: direction.
  - 1 = logical shift right (toward bit 0).
  - 0 = logical shift left (toward bit 7).
- `out` output 8: registered shift result.

## Operation
- Combinational core: three cascaded stages.
  - Stage 0 shifts by 1 when `s_sel[0]` = 1.
  - Stage 1 shifts by 2 when `s_sel[1]` = 1.
  - Stage 2 shifts by 4 when `s_sel[2]` = 1.
- Every stage shifts in the same direction, given by `right`. A disabled stage passes its input through unchanged.
- Result: `data >> s_sel` when `right` = 1, `data << s_sel` when `right` = 0.
- Logical shift only: zeros fill the vacated positions. No sign extension, no rotation, no carry out.
- `s_sel` = 0 returns `data` unchanged in either direction.
- `s_sel` = 7 keeps only one bit:
  - right: `out` = {7'b0, data[7]}.
  - left: `out` = {data[0], 7'b0}.
- Every input combination is legal. No error or overflow flags.

## Timing
- `out` is registered. Latency is 1 cycle: inputs sampled at rising edge N appear on `out` after edge N.
- Throughput is one new operation per cycle. No handshake and no stall.
- Reset:
  - `rst_n` low clears `out` to 8'h00 immediately, independent of `clk`.
  - `out` holds 8'h00 while `rst_n` is low.
  - The first result appears on the first rising edge after `rst_n` deasserts.
- Reset asserted mid-stream discards the pending result. No state other than `out` exists.
- Inputs must be stable for setup/hold around the rising edge. Glitches between edges are invisible at `out`.

## Structure
- Shared package `bishift_pkg`:
  - `WIDTH` = 8.
  - `SEL_W` = 3.
  - Direction constants `DIR_LEFT` = 1'b0 and `DIR_RIGHT` = 1'b1.
- One sub-module, `bishift_stage`:
  - Parameterised by `WIDTH` and `AMT`.
  - Ports: `din`, `en`, `right`, `dout`.
  - Instantiated three times with `AMT` = 1, 2, 4. The stages are chained, and the last stage feeds the output register in the top level.
- The top level contains only the stage chain and the asynchronously reset output flop.

## Test plan
- Reset: `rst_n` low with `data` = 8'hA5, `s_sel` = 3, `right` = 1 → `out` = 8'h00 immediately and while held. Release `rst_n` → after the next edge, `out` = 8'h14.
- Right shifts of `data` = 8'b10100101, one per cycle, checked one cycle later:
  - `s_sel` = 1 → 8'b01010010.
  - `s_sel` = 2 → 8'b00101001.
  - `s_sel` = 3 → 8'b00010100.
  - `s_sel` = 4 → 8'b00001010.
- Left shifts of `data` = 8'b10100101:
  - `s_sel` = 5 → 8'b10100000.
  - `s_sel` = 6 → 8'b01000000.
  - `s_sel` = 7 → 8'b10000000.
- Identity and extremes:
  - `s_sel` = 0 with `data` = 8'hA5 → 8'hA5 in both directions.
  - `data` = 8'hFF, `s_sel` = 7, `right` = 1 → 8'h01.
  - `data` = 8'hFF, `s_sel` = 7, `right` = 0 → 8'h80.
- Back-to-back direction toggle:
  - Alternate `right` each cycle with `data` = 8'h81 and `s_sel` = 1 → outputs alternate 8'h40 (right) and 8'h02 (left), each exactly one cycle after its inputs.
- Exhaustive: all 256 × 8 × 2 input combinations → each `out` matches the reference model (`data >> s_sel` or `data << s_sel`, truncated to 8 bits) one cycle later.
